// File: rtl/spart_txrx_if.sv
// Processor-side I/O bus of the SPART transmit/receive pair.
// The master is the processor; the slave is spart_txrx.
interface spart_txrx_if;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic [7:0] rate_tx_data;
  logic       tbr;
  logic       rda;
  logic [7:0] data_received;

  modport master (
    output iocs, iorw, ioaddr, rate_tx_data,
    input  tbr, rda, data_received
  );

  modport slave (
    input  iocs, iorw, ioaddr, rate_tx_data,
    output tbr, rda, data_received
  );
endinterface

// File: rtl/spart_txrx.sv
// SPART transmitter/receiver: 8N1 frames, one bit per baud enable tick.
// state     | meaning
// TX_IDLE   | txd held high, tbr = 1, waiting for a buffer write
// TX_SHIFT  | shifting start/data/stop bits out on txd
// RX_IDLE   | waiting for a start bit (0) on a tick
// RX_DATA   | collecting 8 data bits, LSB first
// RX_STOP   | checking the stop bit; good frame updates data_received
module spart_txrx (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              rxd,
  output logic              txd,
  spart_txrx_if.slave       bus
);

  typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_STOP} rx_state_t;

  tx_state_t  tx_state_q, tx_state_d;
  logic [9:0] tx_shift_q, tx_shift_d;
  logic [3:0] tx_cnt_q, tx_cnt_d;

  rx_state_t  rx_state_q, rx_state_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic [2:0] rx_cnt_q, rx_cnt_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rda_q, rda_d;

  logic wr_stb, rd_stb;

  assign wr_stb = bus.iocs & ~bus.iorw & (bus.ioaddr == 2'b00);
  assign rd_stb = bus.iocs &  bus.iorw & (bus.ioaddr == 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_shift_q <= '1;
      tx_cnt_q   <= '0;
      rx_state_q <= RX_IDLE;
      rx_byte_q  <= '0;
      rx_cnt_q   <= '0;
      rx_data_q  <= '0;
      rda_q      <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_shift_q <= tx_shift_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_state_q <= rx_state_d;
      rx_byte_q  <= rx_byte_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_data_q  <= rx_data_d;
      rda_q      <= rda_d;
    end
  end

  // A load in IDLE masks any coincident enable; writes during SHIFT are dropped.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_shift_d = tx_shift_q;
    tx_cnt_d   = tx_cnt_q;
    unique case (tx_state_q)
      TX_IDLE: begin
        if (wr_stb) begin
          tx_shift_d = {1'b1, bus.rate_tx_data, 1'b0};
          tx_cnt_d   = '0;
          tx_state_d = TX_SHIFT;
        end
      end
      TX_SHIFT: begin
        if (enable) begin
          tx_shift_d = {1'b1, tx_shift_q[9:1]};
          tx_cnt_d   = tx_cnt_q + 4'd1;
          if (tx_cnt_q == 4'd9) tx_state_d = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // Frame completion outranks a same-cycle read when updating rda.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_byte_d  = rx_byte_q;
    rx_cnt_d   = rx_cnt_q;
    rx_data_d  = rx_data_q;
    rda_d      = rda_q & ~rd_stb;
    if (enable) begin
      unique case (rx_state_q)
        RX_IDLE: begin
          if (!rxd) begin
            rx_cnt_d   = '0;
            rx_state_d = RX_DATA;
          end
        end
        RX_DATA: begin
          rx_byte_d = {rxd, rx_byte_q[7:1]};
          rx_cnt_d  = rx_cnt_q + 3'd1;
          if (rx_cnt_q == 3'd7) rx_state_d = RX_STOP;
        end
        RX_STOP: begin
          if (rxd) begin
            rx_data_d = rx_byte_q;
            rda_d     = 1'b1;
          end
          rx_state_d = RX_IDLE;
        end
        default: rx_state_d = RX_IDLE;
      endcase
    end
  end

  assign txd               = (tx_state_q == TX_SHIFT) ? tx_shift_q[0] : 1'b1;
  assign bus.tbr           = (tx_state_q == TX_IDLE);
  assign bus.rda           = rda_q;
  assign bus.data_received = rx_data_q;

endmodule

// File: tb/tb_spart_txrx.sv
// Directed bench for spart_txrx: loopback frames, ignored writes, framing
// errors, read/complete collision and mid-frame reset.
module tb_spart_txrx;
  logic clk = 1'b0;
  logic rst;
  logic enable;
  logic rxd;
  logic txd;
  logic loop_en;
  logic rxd_drv;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   nticks;
  logic [19:0] txseq;

  spart_txrx_if bus ();

  always #5 clk = ~clk;

  assign rxd = loop_en ? txd : rxd_drv;

  spart_txrx dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .rxd    (rxd),
    .txd    (txd),
    .bus    (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One baud tick after 50 idle clocks; optionally a buffer read in the same cycle.
  task automatic tick(input bit rd);
    repeat (50) @(posedge clk);
    #1;
    enable = 1'b1;
    if (rd) begin
      bus.iocs = 1'b1; bus.iorw = 1'b1; bus.ioaddr = 2'b00;
    end
    @(posedge clk); #1;
    enable = 1'b0;
    bus.iocs = 1'b0; bus.iorw = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b, input bit with_en);
    bus.iocs = 1'b1; bus.iorw = 1'b0; bus.ioaddr = 2'b00; bus.rate_tx_data = b;
    enable = with_en;
    @(posedge clk); #1;
    bus.iocs = 1'b0; enable = 1'b0;
  endtask

  task automatic read_buf();
    bus.iocs = 1'b1; bus.iorw = 1'b1; bus.ioaddr = 2'b00;
    @(posedge clk); #1;
    bus.iocs = 1'b0; bus.iorw = 1'b0;
  endtask

  // Tick until tbr returns, recording txd before each tick; bounded at 20 ticks.
  task automatic run_until_tbr(input int start);
    nticks = start;
    while (!bus.tbr && nticks < 20) begin
      txseq[nticks] = txd;
      tick(1'b0);
      nticks++;
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop, input bit rd_on_stop);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd_drv = frame[i];
      tick(rd_on_stop && i == 9);
    end
    rxd_drv = 1'b1;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; loop_en = 1'b1; rxd_drv = 1'b1; txseq = '0;
    bus.iocs = 1'b0; bus.iorw = 1'b0; bus.ioaddr = 2'b00; bus.rate_tx_data = 8'h00;
    @(posedge clk); #1;
    rst = 1'b0;
    check("reset_txd", 32'(txd), 32'd1);
    check("reset_tbr", 32'(bus.tbr), 32'd1);
    check("reset_rda", 32'(bus.rda), 32'd0);
    check("reset_data", 32'(bus.data_received), 32'h00);

    tick(1'b0);
    check("idle_enable_txd", 32'(txd), 32'd1);
    check("idle_enable_tbr", 32'(bus.tbr), 32'd1);

    write_byte(8'hAA, 1'b0);
    check("aa_tbr_low", 32'(bus.tbr), 32'd0);
    check("aa_start_bit", 32'(txd), 32'd0);
    run_until_tbr(0);
    check("aa_ticks", 32'(nticks), 32'd10);
    check("aa_txd_seq", 32'(txseq[9:0]), 32'h354);
    check("aa_data", 32'(bus.data_received), 32'hAA);
    check("aa_rda", 32'(bus.rda), 32'd1);

    // Enable coincident with the write must not count as a tick.
    write_byte(8'h39, 1'b1);
    check("39_start_bit", 32'(txd), 32'd0);
    run_until_tbr(0);
    check("39_ticks", 32'(nticks), 32'd10);
    check("39_data", 32'(bus.data_received), 32'h39);
    check("39_tbr", 32'(bus.tbr), 32'd1);

    write_byte(8'hC3, 1'b0);
    repeat (3) tick(1'b0);
    write_byte(8'h55, 1'b0);
    check("busy_write_tbr", 32'(bus.tbr), 32'd0);
    run_until_tbr(3);
    check("busy_write_ticks", 32'(nticks), 32'd10);
    check("busy_write_data", 32'(bus.data_received), 32'hC3);

    loop_en = 1'b0;
    read_buf();
    check("read_clears_rda", 32'(bus.rda), 32'd0);
    check("read_keeps_data", 32'(bus.data_received), 32'hC3);

    send_rx(8'h3C, 1'b0, 1'b0);
    check("frame_err_rda", 32'(bus.rda), 32'd0);
    check("frame_err_data", 32'(bus.data_received), 32'hC3);

    send_rx(8'h3C, 1'b1, 1'b1);
    check("good_frame_rda_vs_read", 32'(bus.rda), 32'd1);
    check("good_frame_data", 32'(bus.data_received), 32'h3C);
    read_buf();
    check("read_after_frame_rda", 32'(bus.rda), 32'd0);
    check("read_after_frame_data", 32'(bus.data_received), 32'h3C);

    loop_en = 1'b1;
    write_byte(8'h0F, 1'b0);
    repeat (5) tick(1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midreset_txd", 32'(txd), 32'd1);
    check("midreset_tbr", 32'(bus.tbr), 32'd1);
    check("midreset_rda", 32'(bus.rda), 32'd0);
    check("midreset_data", 32'(bus.data_received), 32'h00);

    write_byte(8'hF0, 1'b0);
    run_until_tbr(0);
    check("f0_ticks", 32'(nticks), 32'd10);
    check("f0_data", 32'(bus.data_received), 32'hF0);
    check("f0_rda", 32'(bus.rda), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
